// File: rtl/resp_checker_pkg.sv
// Shared types and default widths for the response checker.
// State encoding is fixed so external debug taps can decode it.
package resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NVEC    = 16;
  localparam int DEF_AW      = 4;
  localparam int DEF_CW      = 8;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Shared by the mismatch counter and the idle watchdog.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != {CW{1'b1}}))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/resp_checker.sv
// Response checker: compares strobed DUT samples against an addressed expected store.
// Optional idle watchdog enabled by defining RESP_CHECKER_TIMEOUT_EN.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NVEC    = DEF_NVEC,
  parameter int AW      = DEF_AW,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sample,
  input  logic [WIDTH-1:0] dut_out,
  output logic [AW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] dut_q, dut_d;
  logic             pass_q, pass_d;
  logic [AW-1:0]    fidx_q, fidx_d;
  logic             fvld_q, fvld_d;
  logic             to_q, to_d;

  logic start_acc, mismatch, cmp_mis, last_vec, wd_hit;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // exp_addr is stable across RUN and CMP, so exp_data lines up with the latched sample
  assign mismatch  = |((dut_q ^ exp_data) & exp_mask);
  assign cmp_mis   = (state_q == ST_CMP) && mismatch;
  assign last_vec  = (addr_q == AW'(NVEC - 1));

  sat_counter #(.CW(CW)) u_err_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start_acc),
    .inc     (cmp_mis),
    .count   (err_count)
  );

`ifdef RESP_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_idle;

  assign wd_idle = (state_q == ST_RUN) && !sample;

  sat_counter #(.CW(TW)) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (!wd_idle),
    .inc     (wd_idle),
    .count   (wd_cnt)
  );

  // abort on the TIMEOUT-th consecutive idle RUN cycle
  assign wd_hit = wd_idle && (wd_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_hit         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dut_d   = dut_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = '0;
          pass_d  = 1'b0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (sample) begin
          dut_d   = dut_out;
          state_d = ST_CMP;
        end else if (wd_hit) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_CMP: begin
        if (mismatch && !fvld_q) begin
          fidx_d = addr_q;
          fvld_d = 1'b1;
        end
        if (last_vec) begin
          state_d = ST_DONE;
          // err_count has not yet absorbed this cycle's compare
          pass_d  = (err_count == '0) && !mismatch && !to_q;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dut_q   <= '0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dut_q   <= dut_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
      to_q    <= to_d;
    end
  end

  assign exp_addr      = addr_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_CMP);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;
  assign timeout       = to_q;

endmodule
